// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the MIPS32 arbiter, its three requesters and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mips_mem_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  logic          halted;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    mode;

  modport slave (
    input  halted,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid,
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output mode
  );

  modport master (
    output halted,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid,
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  mode
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: IF/DM/LD share one synchronous memory, one grant per cycle,
// reads return one cycle later to the owning port; run/load hand-over follows `halted`.
module mips_mem_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_mem_arbiter_if.slave       bus
);

  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_LD   = 2'd3
  } owner_e;

  state_e        r_state;
  state_e        w_state_nxt;
  owner_e        r_owner;
  owner_e        w_owner_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;

  logic          w_if_prio;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_ld_gnt;

  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  assign w_if_prio = (r_starve_cnt == SW'(MAX_WAIT));

  // Grants are only issued in a cycle where the mode is not about to change.
  always_comb begin
    w_state_nxt = r_state;
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_ld_gnt    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.halted) begin
          w_state_nxt = ST_DRAIN;
        end else if (bus.if_req && (w_if_prio || !bus.dm_req)) begin
          w_if_gnt = 1'b1;
        end else if (bus.dm_req) begin
          w_dm_gnt = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.halted) begin
          w_state_nxt = ST_RUN;
        end else if (bus.ld_req) begin
          w_ld_gnt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
    if (rst) begin
      w_if_gnt = 1'b0;
      w_dm_gnt = 1'b0;
      w_ld_gnt = 1'b0;
    end
  end

  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_if_gnt) begin
      w_mem_en   = 1'b1;
      w_mem_addr = bus.if_addr;
    end else if (w_dm_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.dm_we;
      w_mem_addr  = bus.dm_addr;
      w_mem_wdata = bus.dm_wdata;
    end else if (w_ld_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.ld_we;
      w_mem_addr  = bus.ld_addr;
      w_mem_wdata = bus.ld_wdata;
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end else if (w_dm_gnt && !bus.dm_we) begin
      w_owner_nxt = OWN_DM;
    end else if (w_ld_gnt && !bus.ld_we) begin
      w_owner_nxt = OWN_LD;
    end
  end

  always_comb begin
    w_starve_nxt = '0;
    if ((r_state == ST_RUN) && bus.if_req && !w_if_gnt) begin
      w_starve_nxt = w_if_prio ? r_starve_cnt : r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.ld_gnt    = w_ld_gnt;

  assign bus.if_rvalid = (r_owner == OWN_IF);
  assign bus.dm_rvalid = (r_owner == OWN_DM);
  assign bus.ld_rvalid = (r_owner == OWN_LD);
  assign bus.rdata     = bus.mem_rdata;

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  assign bus.mode      = r_state;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: reset, load/readback, run entry, IF starvation,
// halt with an outstanding read, and reset during an in-flight read.
module tb_mips_mem_arbiter;

  logic clk;
  logic rst;

  mips_mem_arbiter_if #(.AW(10), .DW(32)) bus ();

  mips_mem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears one cycle after the enable.
  logic [31:0] mem [0:1023];
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int unsigned n_vec;
  int unsigned n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam logic [31:0] W0 = 32'h2801000a;
  localparam logic [31:0] W8 = 32'hfc000000;

  logic exp_if, exp_dm, prev_if, prev_dm;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.halted = 1'b1;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset with every request high
    @(negedge clk); @(negedge clk); #1;
    check("rst_gnts",   {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b000);
    check("rst_rvalid", {bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid}, 3'b000);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mode",   bus.mode, 2'd2);

    // Load writes
    @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'd0; bus.ld_wdata = W0;
    #1;
    check("ld_gnt_first", bus.ld_gnt, 1'b1);
    check("ld_wr_en",     {bus.mem_en, bus.mem_we}, 2'b11);
    check("ld_wr_data",   bus.mem_wdata, W0);

    @(negedge clk);
    bus.ld_addr = 10'd8; bus.ld_wdata = W8;
    #1;
    check("ld_gnt_wr2",   bus.ld_gnt, 1'b1);
    check("ld_wr_norv",   bus.ld_rvalid, 1'b0);

    @(negedge clk);
    bus.ld_we = 1'b0;
    #1;
    check("ld_gnt_rd",    bus.ld_gnt, 1'b1);
    check("ld_rd_addr",   {bus.mem_we, bus.mem_addr}, {1'b0, 10'd8});

    @(negedge clk);
    bus.ld_req = 1'b0; bus.if_req = 1'b1; bus.dm_req = 1'b1;
    #1;
    check("ld_rvalid",    bus.ld_rvalid, 1'b1);
    check("ld_rdata",     bus.rdata, W8);
    check("load_mask",    {bus.if_gnt, bus.dm_gnt, bus.mem_en}, 3'b000);

    // Run entry: one idle LOAD->RUN cycle, then fetch
    @(negedge clk);
    bus.halted = 1'b0; bus.dm_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 10'd0;
    bus.ld_req = 1'b1; bus.ld_addr = 10'd8;
    #1;
    check("exit_mode",    bus.mode, 2'd2);
    check("exit_nogrant", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt, bus.mem_en}, 4'b0000);
    check("exit_norv",    bus.ld_rvalid, 1'b0);

    @(negedge clk); #1;
    check("run_mode",     bus.mode, 2'd0);
    check("run_if_gnt",   {bus.if_gnt, bus.ld_gnt}, 2'b10);
    check("run_if_addr",  bus.mem_addr, 10'd0);

    @(negedge clk);
    bus.if_req = 1'b0; bus.ld_req = 1'b0;
    #1;
    check("run_if_rv",    bus.if_rvalid, 1'b1);
    check("run_if_rdata", bus.rdata, W0);

    // Starvation: IF and DM both held high
    prev_if = 1'b0; prev_dm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 10'd0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd8;
      end
      #1;
      exp_if = (i % 5 == 4);
      exp_dm = !exp_if;
      check($sformatf("starve_gnt%0d", i), {bus.if_gnt, bus.dm_gnt}, {exp_if, exp_dm});
      if (i > 0) begin
        check($sformatf("starve_rv%0d", i), {bus.if_rvalid, bus.dm_rvalid}, {prev_if, prev_dm});
        check($sformatf("starve_rd%0d", i), bus.rdata, prev_if ? W0 : W8);
      end
      prev_if = exp_if;
      prev_dm = exp_dm;
    end

    // Halt with a DM read outstanding
    @(negedge clk);
    bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_addr = 10'd0;
    #1;
    check("halt_prev_rv", bus.if_rvalid, 1'b1);
    check("halt_dm_gnt",  bus.dm_gnt, 1'b1);
    check("halt_mode0",   bus.mode, 2'd0);

    @(negedge clk);
    bus.halted = 1'b1; bus.dm_addr = 10'd8; bus.if_req = 1'b1;
    #1;
    check("halt_dm_rv",   bus.dm_rvalid, 1'b1);
    check("halt_rdata",   bus.rdata, W0);
    check("halt_nogrant", {bus.if_gnt, bus.dm_gnt, bus.ld_gnt, bus.mem_en}, 4'b0000);
    check("halt_mode",    bus.mode, 2'd0);

    @(negedge clk);
    bus.halted = 1'b0;
    #1;
    check("drain_mode",   bus.mode, 2'd1);
    check("drain_gnts",   {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b000);
    check("drain_norv",   {bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid}, 3'b000);

    @(negedge clk); #1;
    check("reload_mode",  bus.mode, 2'd2);
    check("reload_gnts",  {bus.if_gnt, bus.dm_gnt, bus.ld_gnt}, 3'b000);

    // Back in RUN, then reset while the fetch is in flight
    @(negedge clk);
    bus.dm_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'd8;
    #1;
    check("rerun_mode",   bus.mode, 2'd0);
    check("rerun_if_gnt", bus.if_gnt, 1'b1);

    @(posedge clk); #1;
    check("inflight_rv",  bus.if_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_rv",    bus.if_rvalid, 1'b0);
    check("midrst_mode",  bus.mode, 2'd2);
    check("midrst_gnt",   {bus.if_gnt, bus.mem_en}, 2'b00);

    @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
